// File: rtl/util_axis_fifo_pkg.sv
// Shared helpers, default sizes and pointer type for the parametrised AXI-Stream FIFO.
package util_axis_fifo_pkg;

    localparam int DEF_BUS_WIDTH  = 1;
    localparam int DEF_USER_WIDTH = 1;
    localparam int DEF_FIFO_DEPTH = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // One stored beat is {tdata, tuser, tlast}.
    function automatic int entry_width(input int bus_width, input int user_width);
        return bus_width * 8 + user_width + 1;
    endfunction

    localparam int DEF_ENTRY_W = entry_width(DEF_BUS_WIDTH, DEF_USER_WIDTH);
    localparam int DEF_PTR_W   = clog2(DEF_FIFO_DEPTH) + 1;

    typedef logic [DEF_PTR_W-1:0] ptr_t;

endpackage

// File: rtl/util_axis_fifo_ctrl.sv
// Pointer, occupancy and full/empty bookkeeping for util_axis_fifo_param.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module util_axis_fifo_ctrl
    import util_axis_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH         = DEF_FIFO_DEPTH,
    parameter int ALMOST_FULL_THRESH = 12,
    localparam int AW                = clog2(FIFO_DEPTH),
    localparam int PW                = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [PW-1:0] count,
    output logic          empty,
    output logic          almost_full,
    output logic          s_ready
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          full_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        // Ready is registered from next-state pointers, so a read that frees a
        // slot only reopens the slave side on the following cycle.
        ready_d  = ~full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    assign wr_addr     = wr_ptr_q[AW-1:0];
    assign rd_addr     = rd_ptr_q[AW-1:0];
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= PW'(ALMOST_FULL_THRESH));
    assign s_ready     = ready_q;

endmodule

// File: rtl/util_axis_fifo_param.sv
// Parametrised first-word-fall-through AXI-Stream FIFO with tuser/tlast and fill status.
// Define UTIL_AXIS_FIFO_PACKET_MODE_EN to present data only once a whole packet is stored.
module util_axis_fifo_param
    import util_axis_fifo_pkg::*;
#(
    parameter int BUS_WIDTH          = DEF_BUS_WIDTH,
    parameter int USER_WIDTH         = DEF_USER_WIDTH,
    parameter int FIFO_DEPTH         = DEF_FIFO_DEPTH,
    parameter int ALMOST_FULL_THRESH = 12,
    localparam int DW                = BUS_WIDTH * 8,
    localparam int CW                = clog2(FIFO_DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  arstn,
    input  logic [DW-1:0]         s_axis_tdata,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DW-1:0]         m_axis_tdata,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  empty
);

    localparam int EW = entry_width(BUS_WIDTH, USER_WIDTH);
    localparam int AW = CW - 1;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_addr, rd_addr;
    logic [EW-1:0] rd_entry;
    logic          s_ready, wr_en, rd_en, out_vld;

    assign wr_en = s_axis_tvalid & s_ready;
    assign rd_en = out_vld & m_axis_tready;

    util_axis_fifo_ctrl #(
        .FIFO_DEPTH        (FIFO_DEPTH),
        .ALMOST_FULL_THRESH(ALMOST_FULL_THRESH)
    ) u_ctrl (
        .clk        (aclk),
        .rst_n      (arstn),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .count      (count),
        .empty      (empty),
        .almost_full(almost_full),
        .s_ready    (s_ready)
    );

    always_ff @(posedge aclk) begin
        if (wr_en) mem_q[wr_addr] <= {s_axis_tdata, s_axis_tuser, s_axis_tlast};
    end

    assign rd_entry = mem_q[rd_addr];

`ifdef UTIL_AXIS_FIFO_PACKET_MODE_EN
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          wr_last, rd_last, fifo_full;

    assign wr_last   = wr_en & s_axis_tlast;
    assign rd_last   = rd_en & rd_entry[0];
    assign fifo_full = (count == CW'(FIFO_DEPTH));

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (wr_last && !rd_last) pkt_cnt_d = pkt_cnt_q + 1'b1;
        else if (rd_last && !wr_last) pkt_cnt_d = pkt_cnt_q - 1'b1;
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) pkt_cnt_q <= '0;
        else        pkt_cnt_q <= pkt_cnt_d;
    end

    // A full FIFO with no tlast stored releases its head so it cannot deadlock.
    assign out_vld = ~empty & ((pkt_cnt_q != '0) | fifo_full);
`else
    assign out_vld = ~empty;
`endif

    assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = out_vld ? rd_entry : '0;
    assign m_axis_tvalid = out_vld;
    assign s_axis_tready = s_ready;

endmodule
